serial_mag_comparator: RTL

Bit-serial magnitude comparator: the sequential counterpart of the combinational bit-comparator slice chain (equal-in/greater-in -> equal-out/greater-out).
- Loads two WIDTH-bit unsigned operands on a start handshake.
- Applies the slice recurrence to one bit per clock, MSB first, in a single registered slice.
- Reports eq/gt/lt with a one-cycle done pulse.
- Used where a full ripple chain is too large or too slow.

---
 rtl/serial_mag_comparator.sv | 131 +++++++++++++
 1 files changed

// File: rtl/serial_mag_comparator.sv
// serial_mag_comparator
//   Bit-serial unsigned magnitude comparator. Two WIDTH-bit operands are
//   captured on start. One equal/greater slice is then evaluated per clock,
//   MSB first, with its e/g state held in registers. A one-cycle done pulse
//   marks the point where eq/gt/lt become valid. The results are then held
//   until the next compare completes.
//
//   Parameters
//     WIDTH      operand width in bits (>= 1)
//     EARLY_EXIT 1: stop at the first differing bit; 0: always WIDTH cycles
//
//   Ports
//     clk    system clock, rising edge
//     rst    asynchronous active-high reset
//     start  request a compare (ignored while busy)
//     a, b   operands, captured when start is accepted
//     busy   high while bits are being shifted
//     done   one-cycle pulse, results valid
//     eq/gt/lt  registered, held compare result
//
//   state  | meaning
//   IDLE   | waiting for start
//   SHIFT  | one slice evaluated per clock, MSB first
//   FINISH | single-cycle result cycle; start is accepted here too
module serial_mag_comparator #(
  parameter int WIDTH      = 8,
  parameter int EARLY_EXIT = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             eq,
  output logic             gt,
  output logic             lt
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SHIFT  = 2'd1,
    S_FINISH = 2'd2
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_sa;
  logic [WIDTH-1:0] r_sb;
  logic [CW-1:0]    r_cnt;
  logic             r_e;
  logic             r_g;
  logic             r_busy;
  logic             r_done;
  logic             r_eq;
  logic             r_gt;
  logic             r_lt;

  logic w_x;
  logic w_y;
  logic w_e_new;
  logic w_g_new;
  logic w_last;

  // One slice of the comparator chain, fed from the operand MSBs.
  assign w_x     = r_sa[WIDTH-1];
  assign w_y     = r_sb[WIDTH-1];
  assign w_e_new = r_e & ~(w_x ^ w_y);
  assign w_g_new = r_g | (r_e & w_x & ~w_y);

  // Once e drops the result can no longer change, so early exit is safe.
  assign w_last  = (r_cnt == CW'(1)) || ((EARLY_EXIT != 0) && !w_e_new);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_sa    <= '0;
      r_sb    <= '0;
      r_cnt   <= '0;
      r_e     <= 1'b0;
      r_g     <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_eq    <= 1'b0;
      r_gt    <= 1'b0;
      r_lt    <= 1'b0;
    end else begin
      case (r_state)
        S_SHIFT: begin
          r_e   <= w_e_new;
          r_g   <= w_g_new;
          r_sa  <= r_sa << 1;
          r_sb  <= r_sb << 1;
          r_cnt <= r_cnt - CW'(1);
          if (w_last) begin
            r_state <= S_FINISH;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_eq    <= w_e_new;
            r_gt    <= w_g_new;
            r_lt    <= ~w_e_new & ~w_g_new;
          end
        end
        default: begin
          // IDLE and FINISH both accept start, which allows back-to-back use.
          r_done <= 1'b0;
          if (start) begin
            r_state <= S_SHIFT;
            r_busy  <= 1'b1;
            r_sa    <= a;
            r_sb    <= b;
            r_e     <= 1'b1;
            r_g     <= 1'b0;
            r_cnt   <= CW'(WIDTH);
          end else begin
            r_state <= S_IDLE;
          end
        end
      endcase
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign eq   = r_eq;
  assign gt   = r_gt;
  assign lt   = r_lt;

endmodule
